// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned 32x32 -> 64 multiplier that borrows the shared 32-bit
// carry-lookahead adder for 32 shift-add iterations.
module mult_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_m;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;
  logic [5:0]  r_cnt;
  logic        w_run;

  // Handshake: start is accepted only on an edge where the block is IDLE
  // (busy=0); busy covers RUN and DONE, and done pulses for one cycle when
  // product is valid. A start held through DONE is taken on the following
  // IDLE cycle, never in the DONE cycle itself.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == 6'd31) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_m     <= 32'd0;
      r_p_hi  <= 32'd0;
      r_p_lo  <= 32'd0;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m    <= multiplicand;
            r_p_hi <= 32'd0;
            r_p_lo <= multiplier;
            r_cnt  <= 6'd0;
          end
        end
        S_RUN: begin
          // 65-bit {cout, sum, P_lo} shifted right by one keeps the carry.
          {r_p_hi, r_p_lo} <= {add_cout, add_sum, r_p_lo[31:1]};
          r_cnt            <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Adder operands are zero outside RUN so other observers see it quiescent.
  assign w_run       = (r_state == S_RUN);
  assign add_a       = w_run ? r_p_hi : 32'd0;
  assign add_b       = (w_run && r_p_lo[0]) ? r_m : 32'd0;
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);
  assign product     = {r_p_hi, r_p_lo};
  assign o_dbg_state = r_state;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Multi-cycle unsigned 32x32 multiply sequencer that time-shares the datapath's 32-bit carry-lookahead adder. The adder takes two 32-bit operands, has carry-in tied to 0, and returns a 32-bit sum plus carry-out. This block owns the adder's operand inputs and consumes its sum and carry-out. It produces a 64-bit product through 32 shift-add iterations and sits beside the ALU in the execute stage.

## Interface

Parameters:
- none; widths are fixed at 32-bit operands and a 64-bit product.

Ports (name, direction, width, meaning):
- clk  input  1  Single clock. All state updates on the rising edge.
- rst_n  input  1  Reset. Synchronous, active-low.
- start  input  1  Request a multiply. Sampled only in IDLE.
- multiplicand  input  32  Operand M. Captured when start is accepted.
- multiplier  input  32  Operand Q. Captured when start is accepted.
- add_a  output  32  Adder operand A.
- add_b  output  32  Adder operand B.
- add_sum  input  32  Adder sum, combinational response to add_a/add_b.
- add_cout  input  1  Adder carry-out.
- busy  output  1  High in RUN and DONE.
- done  output  1  One-cycle pulse: product is valid.
- product  output  64  Result; held until the next accepted start or reset.

## Operation

Internal state:
- M_reg[31:0]: captured multiplicand.
- P_hi[31:0], P_lo[31:0]: partial product; product = {P_hi, P_lo}.
- cnt[5:0]: iteration counter.

States and transitions:
- IDLE
  - If start=1: M_reg<=multiplicand, P_hi<=0, P_lo<=multiplier, cnt<=0, go to RUN.
  - Otherwise hold.
- RUN, one iteration per cycle:
  - add_a=P_hi; add_b = P_lo[0] ? M_reg : 0.
  - {P_hi, P_lo} <= {add_cout, add_sum, P_lo[31:1]}. The 65-bit value is shifted right by one, keeping the adder carry as the new MSB.
  - cnt<=cnt+1. When cnt==31 this cycle, go to DONE.
- DONE
  - done=1 for exactly this cycle.
  - Go to IDLE unconditionally.

Adder drive and handshake rules:
- In IDLE and DONE, add_a=0 and add_b=0, so the adder is quiescent for other observers.
- start is ignored in RUN and DONE. There is no queueing; the requester must wait for busy=0.
- start in the same cycle done is high is ignored.
- product = {P_hi, P_lo} continuously. It is guaranteed correct only from the done cycle until the next accepted start.
- Arithmetic is unsigned; no overflow is possible (64-bit result).
- When the multiplier is 0 or the multiplicand is 0, all 32 iterations still run. There is no early termination.

## Timing

Reset values (rst_n=0 at a rising edge):
- State IDLE; busy=0; done=0; product=0; add_a=0; add_b=0; cnt=0; M_reg=0.

Reset priority:
- Reset mid-operation (in RUN or DONE) aborts immediately.
- The next cycle is IDLE with all reset values.
- No done pulse is emitted for the aborted operation.

Latency:
- start is accepted at edge E0.
- RUN occupies the cycles after E0 through E32 (32 cycles).
- done is high in the cycle after edge E32, i.e. 33 cycles after acceptance.
- busy is high for 33 cycles, RUN plus DONE.

Back-to-back:
- Earliest next accept is the edge ending the first IDLE cycle after DONE.
- Minimum issue interval is therefore 34 cycles.

Adder path:
- add_a/add_b are combinational from registers.
- add_sum/add_cout must settle within one clock period. That path (the CLA) is the block's critical path.

## Test plan

- Reset: hold rst_n=0 for 2 cycles, then release with start=0 -> busy=0, done=0, product=0, add_a=add_b=0 on every cycle.
- Basic: M=5, Q=3, start pulse -> busy high for 33 cycles; done pulses once 33 cycles after acceptance; product=64'h0000_0000_0000_000F; next cycle busy=0.
- Carry propagation: M=32'hFFFF_FFFF, Q=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 at done. Add_cout=1 must be observed on intermediate iterations.
- Zero operand: M=32'h1234_5678, Q=0 -> full 33-cycle latency; add_b=0 throughout RUN; product=0 at done.
- Start while busy: accept M=7, Q=9; hold start=1 with M=2, Q=2 for the whole operation -> single done with product=63. A second operation (product=4) is accepted only in the IDLE cycle after DONE.
- Reset mid-op: M=Q=32'h8000_0000; assert rst_n=0 at iteration 10 -> no done pulse; next cycle IDLE with product=0. A fresh M=6, Q=7 then yields product=42 at done.
